// File: rtl/writeback_queue.sv
// Writeback stage: merges load and ALU results into an in-order FIFO, drains one
// entry per cycle into the register-file write port, and reports pending writes.
module writeback_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alu_valid,
  input  logic [ADDR_WIDTH-1:0]        alu_rd,
  input  logic [DATA_WIDTH-1:0]        alu_data,
  input  logic                         mem_valid,
  input  logic [ADDR_WIDTH-1:0]        mem_rd,
  input  logic [DATA_WIDTH-1:0]        mem_data,
  output logic                         in_ready,
  output logic                         write,
  output logic [ADDR_WIDTH-1:0]        write_address,
  output logic [DATA_WIDTH-1:0]        write_data,
  input  logic [ADDR_WIDTH-1:0]        query_address_1,
  input  logic [ADDR_WIDTH-1:0]        query_address_2,
  output logic                         pending_1,
  output logic                         pending_2,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] RDY_MAX = CW'(DEPTH - 2);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];

  logic [CW-1:0]         count_q, count_d, base;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, alu_slot, offset;
  logic                  overflow_q, overflow_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  pop, mem_acc, alu_acc;

  // Capacity is judged after the same-cycle pop; the load is older, so it claims a slot first.
  always_comb begin
    pop      = (count_q != '0);
    base     = count_q - CW'(pop);
    mem_acc  = mem_valid && (base < DEPTH_C);
    alu_acc  = alu_valid && ((base + CW'(mem_acc)) < DEPTH_C);
    alu_slot = wr_ptr_q + PW'(mem_acc);
    count_d  = base + CW'(mem_acc) + CW'(alu_acc);
    wr_ptr_d = wr_ptr_q + PW'(mem_acc) + PW'(alu_acc);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    overflow_d = overflow_q | (mem_valid & ~mem_acc) | (alu_valid & ~alu_acc);
    write_d  = pop;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (pop) begin
      waddr_d = rd_q[rd_ptr_q];
      wdata_d = data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
      write_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      overflow_q <= overflow_d;
      write_q    <= write_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (mem_acc) begin
      data_q[wr_ptr_q] <= mem_data;
      rd_q[wr_ptr_q]   <= mem_rd;
    end
    if (alu_acc) begin
      data_q[alu_slot] <= alu_data;
      rd_q[alu_slot]   <= alu_rd;
    end
  end

  always_comb begin
    pending_1 = write_q && (waddr_q == query_address_1);
    pending_2 = write_q && (waddr_q == query_address_2);
    offset    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - rd_ptr_q;
      if (CW'(offset) < count_q) begin
        if (rd_q[i] == query_address_1) pending_1 = 1'b1;
        if (rd_q[i] == query_address_2) pending_2 = 1'b1;
      end
    end
  end

  assign in_ready      = (count_q <= RDY_MAX);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign write         = write_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus random traffic, all scored
// against a queue-based reference model of the writeback stage.
module tb_writeback_queue;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;
  logic alu_valid, mem_valid;
  logic [AW-1:0] alu_rd, mem_rd, qa1, qa2;
  logic [DW-1:0] alu_data, mem_data;
  logic in_ready, write, pending_1, pending_2, overflow;
  logic [AW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic [CW-1:0] count;

  writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .in_ready(in_ready), .write(write), .write_address(write_address),
    .write_data(write_data), .query_address_1(qa1), .query_address_2(qa2),
    .pending_1(pending_1), .pending_2(pending_2), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          m_write, m_ovf;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int checks = 0;
  int failures = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_pend(logic [AW-1:0] a);
    logic p;
    p = m_write && (m_addr == a);
    foreach (mq[i]) if (mq[i].rd == a) p = 1'b1;
    return p;
  endfunction

  // Reference behaviour at one rising edge: pop oldest, then load push, then ALU push.
  task automatic model_edge();
    ent_t e;
    if (reset) begin
      mq.delete();
      m_write = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
      return;
    end
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_write = 1'b1; m_addr = e.rd; m_data = e.d;
    end else begin
      m_write = 1'b0;
    end
    if (mem_valid) begin
      if (mq.size() < DEPTH) begin e.rd = mem_rd; e.d = mem_data; mq.push_back(e); end
      else m_ovf = 1'b1;
    end
    if (alu_valid) begin
      if (mq.size() < DEPTH) begin e.rd = alu_rd; e.d = alu_data; mq.push_back(e); end
      else m_ovf = 1'b1;
    end
  endtask

  task automatic compare();
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("in_ready", 32'(in_ready), 32'(mq.size() <= DEPTH - 2));
    check_eq("write", 32'(write), 32'(m_write));
    check_eq("write_address", 32'(write_address), 32'(m_addr));
    check_eq("write_data", 32'(write_data), 32'(m_data));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("pending_1", 32'(pending_1), 32'(m_pend(qa1)));
    check_eq("pending_2", 32'(pending_2), 32'(m_pend(qa2)));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic drive(input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                       input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1; qa1 = '0; qa2 = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    m_write = 1'b0; m_addr = '0; m_data = '0; m_ovf = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);

    // Single ALU push
    qa1 = 3'd3; qa2 = 3'd4;
    drive(1'b0, '0, '0, 1'b1, 3'd3, 16'h1234);
    idle(3);

    // Same-cycle load and ALU, load written first
    qa1 = 3'd2; qa2 = 3'd5;
    drive(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd5, 16'h5555);
    idle(3);

    // Duplicate destination
    qa1 = 3'd1; qa2 = 3'd0;
    drive(1'b1, 3'd1, 16'h0001, 1'b1, 3'd1, 16'h0002);
    idle(4);

    // Sustained dual pushes into overflow, then drain
    for (int i = 0; i < 5; i++)
      drive(1'b1, AW'(i), DW'(16'h100 + i), 1'b1, AW'(i + 4), DW'(16'h200 + i));
    idle(7);

    // Reset mid-drain discards everything
    reset = 1'b1; idle(1); reset = 1'b0;
    drive(1'b1, 3'd6, 16'hBEEF, 1'b1, 3'd7, 16'hCAFE);
    qa1 = 3'd6; qa2 = 3'd7;
    drive(1'b1, 3'd6, 16'hF00D, 1'b1, 3'd7, 16'hD00D);
    reset = 1'b1; idle(1); reset = 1'b0;
    idle(3);

    // Pointer wrap with ten sequential pushes
    for (int i = 0; i < 10; i++) drive(1'b0, '0, '0, 1'b1, AW'(i), DW'(i));
    idle(3);

    // Random traffic, mostly well-behaved producers with occasional forced pushes
    for (int i = 0; i < 600; i++) begin
      logic ok;
      ok = (mq.size() <= DEPTH - 2) || ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 60) == 0);
      qa1 = AW'($urandom); qa2 = AW'($urandom);
      drive(ok && $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom),
            ok && $urandom_range(0, 2) != 0, AW'($urandom), DW'($urandom));
    end
    reset = 1'b0;
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
